// File: rtl/bank_pkg.sv
// Shared constants and state encoding for the bank storage block and its
// read/write initiators.
package bank_pkg;

    localparam int DATA_W      = 128;
    localparam int ADDR_W      = 7;
    localparam int BANK_RD_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } bank_rd_state_t;

endpackage

// File: rtl/bank_reader_if.sv
// Command, bank read port and output stream of the bank reader.
// The master modport is the reader; the slave modport is its environment.
interface bank_reader_if #(
    parameter int DATA_W = bank_pkg::DATA_W,
    parameter int ADDR_W = bank_pkg::ADDR_W
);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              vsi_outputChipSelect;
    logic [ADDR_W-1:0] vsi_outputAddr;
    logic [DATA_W-1:0] vsi_outputData;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  start, base_addr, count, vsi_outputData, m_ready,
        output busy, done, vsi_outputChipSelect, vsi_outputAddr,
               m_valid, m_data, m_last
    );

    modport slave (
        output start, base_addr, count, vsi_outputData, m_ready,
        input  busy, done, vsi_outputChipSelect, vsi_outputAddr,
               m_valid, m_data, m_last
    );

endinterface

// File: rtl/bank_rd_fifo.sv
// Synchronous FIFO that buffers bank read data; head word is visible
// combinationally and reads as zero while empty.
module bank_rd_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_used,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_used;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // NOTE: storage has no reset; the empty flag masks stale words instead.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: state registers use non-blocking assignment so every reader sees
    // the pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_used <= r_used + (PTR_W+1)'(1);
                2'b01:   r_used <= r_used - (PTR_W+1)'(1);
                default: r_used <= r_used;
            endcase
        end
    end

    assign o_empty = (r_used == '0);
    assign o_full  = (r_used == (PTR_W+1)'(DEPTH));
    assign o_used  = r_used;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/bank_reader.sv
// Sweeps a wrapping address range of the bank and streams the words out,
// issuing reads only while the return FIFO is guaranteed to have room.
module bank_reader #(
    parameter int DATA_W     = bank_pkg::DATA_W,
    parameter int ADDR_W     = bank_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          vsi_clk,
    input  logic          vsi_reset,
    bank_reader_if.master bus
);

    import bank_pkg::*;

    localparam int USED_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W  = USED_W + 1;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    bank_rd_state_t         r_state;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_cs;
    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W:0]        r_count;
    logic [ADDR_W:0]        r_issued;
    logic [ADDR_W:0]        r_beat;
    logic [BANK_RD_LAT-1:0] r_inflight;

    logic [USED_W-1:0]      w_used;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_last;
    logic                   w_credit;
    logic [CNT_W-1:0]       w_outstanding;
    logic [DATA_W-1:0]      w_head;

    // Words already owed to the FIFO: buffered, on the bank bus, or being read.
    // NOTE: always_comb assigns a default first so no path infers a latch.
    always_comb begin
        w_outstanding = CNT_W'(w_used) + CNT_W'(r_cs);
        for (int i = 0; i < BANK_RD_LAT; i++) begin
            w_outstanding = w_outstanding + CNT_W'(r_inflight[i]);
        end
    end

    assign w_credit = ~w_full & (w_outstanding < CNT_W'(FIFO_DEPTH));
    assign w_push   = r_inflight[BANK_RD_LAT-1];
    assign w_pop    = ~w_empty & bus.m_ready;
    assign w_last   = ~w_empty & (r_beat + CNT_ONE == r_count);

    always_ff @(posedge vsi_clk or posedge vsi_reset) begin
        if (vsi_reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= 1'b0;
            r_addr     <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_beat     <= '0;
            r_inflight <= '0;
        end else begin
            r_inflight <= (r_inflight << 1) | BANK_RD_LAT'(r_cs);
            if (w_pop) r_beat <= r_beat + CNT_ONE;

            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        if (bus.count != '0) begin
                            r_state  <= RUN;
                            r_busy   <= 1'b1;
                            r_cs     <= 1'b1;
                            r_addr   <= bus.base_addr;
                            r_count  <= bus.count;
                            r_issued <= CNT_ONE;
                            r_beat   <= '0;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // r_issued counts reads already scheduled, including this cycle's.
                    if (r_issued == r_count) begin
                        r_cs    <= 1'b0;
                        r_state <= DRAIN;
                    end else if (w_credit) begin
                        r_cs     <= 1'b1;
                        r_addr   <= r_addr + ADDR_W'(1);
                        r_issued <= r_issued + CNT_ONE;
                    end else begin
                        r_cs <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    bank_rd_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (vsi_clk),
        .rst     (vsi_reset),
        .i_push  (w_push),
        .i_data  (bus.vsi_outputData),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_used  (w_used),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign bus.busy                 = r_busy;
    assign bus.done                 = r_done;
    assign bus.vsi_outputChipSelect = r_cs;
    assign bus.vsi_outputAddr       = r_addr;
    assign bus.m_valid              = ~w_empty;
    assign bus.m_data               = w_head;
    assign bus.m_last               = w_last;

endmodule

// File: doc/bank_reader.md
# bank_reader

Read-side initiator for the 128-entry × 128-bit `bank` storage block. On a start command it sweeps a contiguous, wrapping address range through the bank's output port (`vsi_outputChipSelect` / `vsi_outputAddr` / `vsi_outputData`). It returns the words as a valid/ready stream with a last-beat marker. A small internal FIFO absorbs the bank's fixed read latency, so downstream backpressure never loses a word.

## Interface
Parameters:
- `DATA_W`, 128, bank word width
- `ADDR_W`, 7, bank address width; bank depth = 2^ADDR_W
- `FIFO_DEPTH`, 4, read-return buffer entries; power of two, ≥ 2

Ports:
- `vsi_clk`  in  1  clock
- `vsi_reset`  in  1  asynchronous, active-high reset
- `start`  in  1  command strobe, sampled when `busy`=0
- `base_addr`  in  ADDR_W  first bank address
- `count`  in  ADDR_W+1  words to read, 0..2^ADDR_W
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle completion pulse
- `vsi_outputChipSelect`  out  1  bank read enable
- `vsi_outputAddr`  out  ADDR_W  bank read address
- `vsi_outputData`  in  DATA_W  bank read data, valid BANK_RD_LAT=1 cycle after the read strobe
- `m_valid`  out  1  stream data valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  DATA_W  stream word
- `m_last`  out  1  final beat of command

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 and `count`≠0 → latch `base_addr` and `count`; go to RUN.
  - `start`=1 and `count`=0 → go to DONE directly; no bank access.
- RUN: issue one read per cycle while `fifo_used + inflight < FIFO_DEPTH`.
  - Read address = `base_addr + issued`, mod 2^ADDR_W. Wrap 127→0 is silent.
  - Last read issued → go to DRAIN.
- DRAIN: no reads. Go to DONE on the handshake of the final beat.
- DONE: one cycle, `done`=1 → IDLE.
- `inflight`: one-bit pending flag per latency stage. Set on issue; the returned word is written to the FIFO on the following edge.
- FIFO head drives `m_data`. `m_valid` = FIFO non-empty. Pop on `m_valid & m_ready`.
- `m_last` = head word is beat index `count-1`. Tracked by a beat counter on pops.
- `start` while `busy`=1 is ignored; no queuing.
- `vsi_outputAddr` holds its last value when the chip select is low. Its value is don't-care to the bank.

## Timing
- Reset value of every output: 0. This covers `busy`, `done`, `vsi_outputChipSelect`, `vsi_outputAddr`, `m_valid`, `m_data`, `m_last`.
- Reset clears state, counters, inflight flags and the FIFO.
  - Reset mid-command aborts it. Data returning after reset is discarded.
  - No `done` pulse for an aborted command.
- `start` sampled at edge E0:
  - `busy`=1 and first chip select in cycle E0+1.
  - First word is on the bank bus in E0+2, written to the FIFO at the end of E0+2.
  - `m_valid`=1 from E0+3. Start-to-first-beat latency is 3 cycles.
- With `m_ready` held at 1: one beat per cycle, N words occupy cycles E0+3 .. E0+N+2.
- `busy` drops and `done`=1 in the cycle after the final handshake.
- `count`=0: `done`=1 in E0+1; `busy` stays 0.
- Backpressure: while `m_valid & !m_ready`, `m_data` and `m_last` are held stable. Chip select stalls once `fifo_used + inflight = FIFO_DEPTH`.
- Overflow is impossible by construction; the bench asserts this.
- Same-cycle FIFO push and pop is legal when full; occupancy is unchanged.
- FIFO_DEPTH=4 sustains full throughput at BANK_RD_LAT=1.

## Structure
- `bank_pkg`: holds `DATA_W`, `ADDR_W`, `BANK_RD_LAT`=1 and the state enum `bank_rd_state_t` {IDLE, RUN, DRAIN, DONE}. Shared with `bank` and future bank writers.
- Sub-module `bank_rd_fifo`:
  - Synchronous FIFO, parameterised width and depth, asynchronous active-high reset.
  - Exposes `used`, `empty` and `full`.
- Top level holds the FSM, address and issue counters, inflight tracking and the beat counter.

## Test plan
- Preload `bank[i]` = {16{i[7:0]}}. `base_addr`=2, `count`=5, `m_ready`=1 → beats carry addresses 2..6 in E0+3..E0+7, `m_last` on address 6, `done` in E0+8.
- Wrap: `base_addr`=126, `count`=4 → address order 126, 127, 0, 1. Data matches; exactly 4 chip-select cycles.
- Backpressure: `count`=10, `m_ready` low for cycles E0+4..E0+9, then 1 → chip select stops with 4 words buffered/in flight. All 10 words arrive in order, no drop or duplicate, data stable while stalled.
- `count`=0 → `done` in E0+1, chip select never asserts. `count`=128, `base_addr`=0 → 128 beats, `m_last` only on beat 127.
- `start` pulsed mid-command → ignored: beat count and `done` timing unchanged.
- Reset asserted after beat 3 of a 10-word command → all outputs 0 immediately, no stale beat after release. A new command `base_addr`=0, `count`=2 completes normally.
